// File: rtl/lsu_access.sv
// lsu_access: memory-access stage between execute and the write-back data mux.
// It takes one load/store request, runs one data-memory bus transaction, and
// returns the formatted load result (or a store ack, or a fault) to write-back.
// Optional build macro: LSU_MISALIGN_CHECK_EN. When it is defined, misaligned
// half and word accesses fault in IDLE and no bus request is issued.
module lsu_access #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_ren,
  input  logic        in_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  // Timeout compare is done one bit wider so that the increment cannot wrap.
  localparam logic [TO_W:0] TMO = (TO_W+1)'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      f3_q, f3_d;
  logic            wen_q, wen_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            ld_ok, st_ok, misalign, req_err;
  logic [31:0]     st_wdata;
  logic [3:0]      st_wmask;
  logic [31:0]     ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [TO_W:0]   cnt_inc;

  // Request decode: legality, optional alignment check, store lane formatting.
  always_comb begin
    ld_ok    = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
               (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    st_ok    = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    // funct3[1:0] encodes the access size for every legal load/store.
    misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
               ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
`endif
    req_err  = (in_ren && in_wen) || (in_ren && !ld_ok) || (in_wen && !st_ok) ||
               ((in_ren || in_wen) && misalign);
    st_wdata = 32'h0;
    st_wmask = 4'h0;
    if (in_wen) begin
      case (in_funct3[1:0])
        2'b00:   begin st_wdata = {4{in_wdata[7:0]}};  st_wmask = 4'b0001 << in_addr[1:0]; end
        2'b01:   begin st_wdata = {2{in_wdata[15:0]}}; st_wmask = 4'b0011 << {in_addr[1], 1'b0}; end
        2'b10:   begin st_wdata = in_wdata;            st_wmask = 4'b1111; end
        default: begin st_wdata = 32'h0;               st_wmask = 4'h0; end
      endcase
    end
  end

  // Load result formatting from the captured lane and funct3.
  always_comb begin
    ld_byte = mem_resp_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      3'b010:  ld_data = mem_resp_rdata;
      default: ld_data = 32'h0;
    endcase
  end

  // Next-state and datapath register updates for the IDLE/REQ/WAIT/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_inc = {1'b0, cnt_q} + (TO_W+1)'(1);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = {in_addr[31:2], 2'b00};
          lane_d  = in_addr[1:0];
          f3_d    = in_funct3;
          wen_d   = in_wen;
          wdata_d = st_wdata;
          wmask_d = st_wmask;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          if (!in_ren && !in_wen) begin
            state_d = S_DONE;
          end else if (req_err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[TO_W-1:0];
        if (mem_resp_valid) begin
          // A store ack carries no data back to write-back.
          rdata_d = wen_q ? 32'h0 : ld_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_inc == TMO)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      lane_q  <= 2'b00;
      f3_q    <= 3'b000;
      wen_q   <= 1'b0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign out_valid     = (state_q == S_DONE);
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_lsu_access.sv
// Bench for lsu_access: a simple bus responder plus a reference model of the
// load/store formatting rules, driven by directed and random transactions.
module tb_lsu_access;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_ren = 1'b0, in_wen = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [64];

  lsu_access #(.TIMEOUT(TMO), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_ren(in_ren), .in_wen(in_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value a load returns, from byte/half arithmetic on the memory word.
  function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
    int v;
    case (f3)
      3'd0, 3'd4: begin
        v = int'((w >> (8 * (a % 4))) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = int'((w >> (16 * ((a % 4) / 2))) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      3'd2: v = int'(w);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit ref_err(logic [2:0] f3, logic ren, logic wen, logic [31:0] a);
    int size;
    if (!ren && !wen) return 1'b0;
    if (ren && wen) return 1'b1;
    if (ren && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (wen && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    size = 1 << f3[1:0];
`ifdef LSU_MISALIGN_CHECK_EN
    if ((a % size) != 0) return 1'b1;
`else
    if (size < 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_mask(logic [2:0] f3, logic [31:0] a);
    case (f3)
      3'd0: return 4'(1 << (a % 4));
      3'd1: return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0: return (d & 32'hFF) * 32'h0101_0101;
      3'd1: return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Drives one request and plays the bus/write-back side; reports what it saw.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input logic ren, input logic wen, input int rq_dly, input int rs_dly,
                         input bit rs_en, input int hold,
                         output logic [31:0] o_rdata, output logic o_err, output int lat,
                         output bit seen, output logic [31:0] q_addr, output logic [31:0] q_wdata,
                         output logic [3:0] q_wmask, output logic q_wen,
                         output bit unstable, output bit rdy_bad, output bit hung);
    int rq_cnt, rs_cnt;
    bit hs, sent, got;
    seen = 0; unstable = 0; rdy_bad = 0; hung = 0; lat = 0;
    hs = 0; sent = 0; got = 0; rq_cnt = 0; rs_cnt = 0;
    o_rdata = '0; o_err = 1'b0; q_addr = '0; q_wdata = '0; q_wmask = '0; q_wen = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    if (!in_ready) hung = 1;
    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_funct3 = f3; in_ren = ren; in_wen = wen;
    for (int i = 1; i <= 80 && !got; i++) begin
      @(negedge clk);
      in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      if (in_ready) rdy_bad = 1;
      if (out_valid) begin
        got = 1; lat = i; o_rdata = out_rdata; o_err = out_err;
      end else if (mem_req_valid) begin
        if (!seen) begin
          seen = 1; q_addr = mem_req_addr; q_wdata = mem_req_wdata;
          q_wmask = mem_req_wmask; q_wen = mem_req_wen;
        end else if (q_addr !== mem_req_addr || q_wdata !== mem_req_wdata ||
                     q_wmask !== mem_req_wmask || q_wen !== mem_req_wen) begin
          unstable = 1;
        end
        if (rq_cnt == rq_dly) begin mem_req_ready = 1'b1; hs = 1; end
        else rq_cnt++;
      end else if (hs && rs_en && !sent) begin
        if (rs_cnt == rs_dly) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = mem[a[7:2]]; sent = 1;
          if (wen) begin
            for (int b = 0; b < 4; b++)
              if (ref_mask(f3, a)[b]) mem[a[7:2]][8*b +: 8] = ref_wdata(f3, wd)[8*b +: 8];
          end
        end else rs_cnt++;
      end
    end
    if (!got) hung = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_rdata !== o_rdata || out_err !== o_err || in_ready) unstable = 1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) rdy_bad = 1;
  endtask

  logic [31:0] r_rdata, r_addr, r_wdata;
  logic        r_err, r_wen;
  logic [3:0]  r_wmask;
  int          r_lat;
  bit          r_seen, r_unst, r_rdy, r_hung;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({in_ready, mem_req_valid, out_valid, out_err} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 1000", {in_ready, mem_req_valid, out_valid, out_err});
    end
    n_chk++;
    if (out_rdata !== 32'h0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 ||
        mem_req_wmask !== 4'h0 || mem_req_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wmask=%b wen=%b expected all zero",
                         out_rdata, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen);
    end
  endtask

  task automatic test_load_fmt();
    mem[0] = 32'h80FF_1234;
    run_txn(32'h1003, 0, 3'd0, 1, 0, 0, 0, 1, 0, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
    n_chk++;
    if (r_rdata !== 32'hFFFF_FF80 || r_err !== 1'b0) begin
      n_fail++; $display("FAIL lb_value: got %h err=%b expected ffffff80 err=0", r_rdata, r_err);
    end
    n_chk++;
    if (r_lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", r_lat); end
    n_chk++;
    if (r_addr !== 32'h1000 || r_wmask !== 4'h0 || r_wen !== 1'b0) begin
      n_fail++; $display("FAIL lb_req: addr=%h wmask=%b wen=%b expected 00001000 0000 0", r_addr, r_wmask, r_wen);
    end
    mem[0] = 32'h8001_7FFF;
    run_txn(32'h2002, 0, 3'd5, 1, 0, 0, 0, 1, 0, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
    n_chk++;
    if (r_rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_value: got %h expected 00008001", r_rdata); end
    run_txn(32'h2002, 0, 3'd1, 1, 0, 0, 0, 1, 0, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
    n_chk++;
    if (r_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_value: got %h expected ffff8001", r_rdata); end
  endtask

  task automatic test_store();
    mem[4] = 32'h1111_2222;
    run_txn(32'h11, 32'h0000_00AB, 3'd0, 0, 1, 0, 0, 1, 0, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
    n_chk++;
    if (r_addr !== 32'h10 || r_wmask !== 4'b0010 || r_wdata !== 32'hABAB_ABAB || r_wen !== 1'b1) begin
      n_fail++; $display("FAIL sb_req: addr=%h wmask=%b wdata=%h wen=%b expected 00000010 0010 abababab 1",
                         r_addr, r_wmask, r_wdata, r_wen);
    end
    n_chk++;
    if (r_rdata !== 32'h0 || r_err !== 1'b0 || r_lat !== 3) begin
      n_fail++; $display("FAIL sb_result: rdata=%h err=%b lat=%0d expected 0 0 3", r_rdata, r_err, r_lat);
    end
  endtask

  task automatic test_stall();
    mem[5] = 32'hCAFE_F00D;
    run_txn(32'h14, 0, 3'd2, 1, 0, 5, 3, 1, 3, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
    n_chk++;
    if (r_unst || r_rdy || r_hung) begin
      n_fail++; $display("FAIL stall_handshake: unstable=%b ready_bad=%b hung=%b expected 0 0 0", r_unst, r_rdy, r_hung);
    end
    n_chk++;
    if (r_rdata !== 32'hCAFE_F00D || r_lat !== 11) begin
      n_fail++; $display("FAIL stall_result: rdata=%h lat=%0d expected cafef00d 11", r_rdata, r_lat);
    end
  endtask

  task automatic test_timeout();
    bit stray;
    run_txn(32'h20, 0, 3'd2, 1, 0, 0, 0, 0, 0, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
    n_chk++;
    if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat !== 2 + TMO) begin
      n_fail++; $display("FAIL timeout: err=%b rdata=%h lat=%0d expected 1 0 %0d", r_err, r_rdata, r_lat, 2 + TMO);
    end
    stray = 0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || !in_ready) stray = 1;
      @(negedge clk);
    end
    n_chk++;
    if (stray) begin n_fail++; $display("FAIL stray_resp: got output activity expected none"); end
  endtask

  task automatic test_rst_wait();
    bit bad;
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h40; in_funct3 = 3'd2; in_ren = 1'b1; in_wen = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_setup: mem_req_valid=%b expected 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0; mem_resp_valid = 1'b0;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_wait: in_ready=%b out_valid=%b req_valid=%b expected 1 0 0",
                         in_ready, out_valid, mem_req_valid);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid || out_rdata !== 32'h0) bad = 1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL rst_drop_resp: output seen after reset expected none"); end
  endtask

  task automatic test_misalign();
    mem[1] = 32'h0BAD_CAFE;
    run_txn(32'h6, 0, 3'd2, 1, 0, 0, 0, 1, 0, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
`ifdef LSU_MISALIGN_CHECK_EN
    n_chk++;
    if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_seen || r_lat !== 1) begin
      n_fail++; $display("FAIL misalign_lw: err=%b rdata=%h bus=%b lat=%0d expected 1 0 0 1", r_err, r_rdata, r_seen, r_lat);
    end
`else
    n_chk++;
    if (r_err !== 1'b0 || r_rdata !== 32'h0BAD_CAFE || r_addr !== 32'h4) begin
      n_fail++; $display("FAIL misalign_lw: err=%b rdata=%h addr=%h expected 0 0badcafe 00000004", r_err, r_rdata, r_addr);
    end
`endif
  endtask

  task automatic test_illegal_bubble();
    logic [2:0] f3s [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
    logic       rens[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       wens[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       errs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      run_txn(32'h30, 32'h55, f3s[k], rens[k], wens[k], 0, 0, 1, 1, r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
      n_chk++;
      if (r_err !== errs[k] || r_rdata !== 32'h0 || r_seen || r_lat !== 1) begin
        n_fail++; $display("FAIL no_bus_case%0d: err=%b rdata=%h bus=%b lat=%0d expected %b 0 0 1",
                           k, r_err, r_rdata, r_seen, r_lat, errs[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp_rd;
    logic [2:0]  f3;
    logic        ren, wen, exp_err;
    int          rq, rs, exp_lat;
    bit          nobus;
    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, 255); wd = $urandom; f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: begin ren = 0; wen = 0; end
        1: begin ren = 1; wen = 1; end
        2, 3, 4, 5: begin ren = 1; wen = 0; end
        default: begin ren = 0; wen = 1; end
      endcase
      if ($urandom_range(0, 3) != 0) f3 = (ren ? 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'd4 : 3'd0) : 3'($urandom_range(0, 2)));
      if (ren && f3 == 3'd6) f3 = 3'd2;
      rq = $urandom_range(0, 3); rs = $urandom_range(0, 3);
      exp_err = ref_err(f3, ren, wen, a);
      nobus   = exp_err || (!ren && !wen);
      exp_rd  = (ren && !nobus) ? ref_load(mem[a[7:2]], f3, a) : 32'h0;
      exp_lat = nobus ? 1 : rq + rs + 3;
      run_txn(a, wd, f3, ren, wen, rq, rs, 1, $urandom_range(0, 2), r_rdata, r_err, r_lat, r_seen, r_addr, r_wdata, r_wmask, r_wen, r_unst, r_rdy, r_hung);
      n_chk++;
      if (r_rdata !== exp_rd || r_err !== exp_err || r_lat !== exp_lat || r_seen !== !nobus) begin
        n_fail++; $display("FAIL rand%0d_result: a=%h f3=%0d r=%b w=%b got rdata=%h err=%b lat=%0d bus=%b expected %h %b %0d %b",
                           n, a, f3, ren, wen, r_rdata, r_err, r_lat, r_seen, exp_rd, exp_err, exp_lat, !nobus);
      end
      n_chk++;
      if (r_unst || r_rdy || r_hung) begin
        n_fail++; $display("FAIL rand%0d_handshake: unstable=%b ready_bad=%b hung=%b expected 0 0 0", n, r_unst, r_rdy, r_hung);
      end
      if (!nobus) begin
        n_chk++;
        if (r_addr !== (a & ~32'h3) || r_wen !== wen ||
            (wen && (r_wmask !== ref_mask(f3, a) || r_wdata !== ref_wdata(f3, wd))) ||
            (!wen && r_wmask !== 4'h0)) begin
          n_fail++; $display("FAIL rand%0d_req: addr=%h wen=%b wmask=%b wdata=%h expected %h %b %b %h", n,
                             r_addr, r_wen, r_wmask, r_wdata, a & ~32'h3, wen, wen ? ref_mask(f3, a) : 4'h0, ref_wdata(f3, wd));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_load_fmt();
    test_store();
    test_stall();
    test_timeout();
    test_rst_wait();
    test_misalign();
    test_illegal_bubble();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
